regfile_sb: RTL

- Parametrised, scoreboarded integer register file for the pipelined core.
- Register count, data width and number of read ports are configurable; register 0 is hardwired to zero.
- Adds a per-register busy bit, set when an instruction reserves its destination at issue and cleared at writeback, so the issue stage can stall on RAW hazards.
- Provides optional write-to-read bypass and a pipeline flush that clears all reservations.

---
 rtl/regfile_sb_pkg.sv | 15 +
 rtl/regfile_sb_scoreboard.sv | 75 +++++++
 rtl/regfile_sb.sv | 79 +++++++
 3 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared constants for the scoreboarded register file: default sizes,
// the address-width derivation and the hardwired zero register index.
package regfile_sb_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;
    localparam int ZERO_REG  = 0;

    // Address width for a register file of n entries (n is a power of 2).
    function automatic int addr_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set by issue-stage reservations,
// cleared by writeback or a pipeline flush, plus per-read-port busy lookup.
// Optional macro REGFILE_SB_BYPASS_EN: a same-cycle writeback to the looked-up
// register reports not-busy (unless the same register is reserved that cycle).
module regfile_sb_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = NRD_DEF,
    parameter int AW    = addr_width(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic              rsv_valid,
    input  logic [AW-1:0]     rsv_addr,
    input  logic              flush,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD-1:0]    rbusy,
    output logic              any_busy
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;

    // Next busy vector: writeback clears, then flush clears all or a reserve
    // sets (reserve applied last so a newer producer wins over the writeback).
    always_comb begin
        busy_next = busy;
        if (we && wa != ZERO_ADDR)
            busy_next[wa] = 1'b0;
        if (flush)
            busy_next = '0;
        else if (rsv_valid && rsv_addr != ZERO_ADDR)
            busy_next[rsv_addr] = 1'b1;
        busy_next[ZERO_REG] = 1'b0;
    end

    // Busy register, cleared asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy <= '0;
        else
            busy <= busy_next;
    end

    // Pipeline-drain indicator over all real registers.
    always_comb begin
        any_busy = |busy[NREGS-1:1];
    end

    for (genvar g = 0; g < NRD; g++) begin : g_lookup
        logic [AW-1:0] a;
        logic          b;
        assign a = ra[g*AW +: AW];

        // Busy lookup for read port g; register 0 is never busy.
        always_comb begin
            b = 1'b0;
            if (a != ZERO_ADDR) begin
                b = busy[a];
`ifdef REGFILE_SB_BYPASS_EN
                if (we && wa == a)
                    b = rsv_valid && (rsv_addr == a);
`endif
            end
        end

        assign rbusy[g] = b;
    end

endmodule

// File: rtl/regfile_sb.sv
// Scoreboarded integer register file: NREGS x XLEN storage, register 0 reads
// as zero, NRD combinational read ports with per-port busy flags.
// Optional macro REGFILE_SB_BYPASS_EN: read ports forward a same-cycle
// writeback (data and busy) instead of returning stored state only.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = NRD_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NRD*addr_width(NREGS)-1:0] ra,
    output logic [NRD*XLEN-1:0]        rdata,
    output logic [NRD-1:0]             rbusy,
    input  logic                       we,
    input  logic [addr_width(NREGS)-1:0] wa,
    input  logic [XLEN-1:0]            wd,
    input  logic                       rsv_valid,
    input  logic [addr_width(NREGS)-1:0] rsv_addr,
    input  logic                       flush,
    output logic                       any_busy
);

    localparam int AW = addr_width(NREGS);
    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

    logic [XLEN-1:0] regs [NREGS];

    regfile_sb_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .AW    (AW)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .wa        (wa),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .flush     (flush),
        .ra        (ra),
        .rbusy     (rbusy),
        .any_busy  (any_busy)
    );

    // Data array: cleared on reset, written at writeback; writes to r0 dropped.
    // A flush does not block the write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (we && wa != ZERO_ADDR) begin
            regs[wa] <= wd;
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_read
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        assign a = ra[g*AW +: AW];

        // Read mux for port g: zero for r0, else stored (or forwarded) data.
        always_comb begin
            d = '0;
            if (a != ZERO_ADDR) begin
                d = regs[a];
`ifdef REGFILE_SB_BYPASS_EN
                if (we && wa == a)
                    d = wd;
`endif
            end
        end

        assign rdata[g*XLEN +: XLEN] = d;
    end

endmodule
